// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexes a 0..15 value onto a two-digit 7-segment display with blanking gaps
module seg_scan_driver #(
  parameter int SCAN_DIV = 1000,
  parameter int GAP_CYC  = 8
) (
  input  logic       clk,
  input  logic       cr,
  input  logic [3:0] data,
  input  logic       upd,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] sel,
  output logic       ovf,
  output logic       frm
);
  // Encoding order matches the scan cycle so advancing is a simple increment with wrap.
  typedef enum logic [1:0] {GAP1 = 2'd0, ONES = 2'd1, GAP0 = 2'd2, TENS = 2'd3} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_shd;
  logic [3:0]  r_disp;
  logic        r_frm;
  logic [15:0] w_len;
  logic        w_last;
  logic        w_tens;
  logic [3:0]  w_ones;
  logic        w_blank_tens;
  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b1111110;
      4'd1:    seg_pat = 7'b0110000;
      4'd2:    seg_pat = 7'b1101101;
      4'd3:    seg_pat = 7'b1111001;
      4'd4:    seg_pat = 7'b0110011;
      4'd5:    seg_pat = 7'b1011011;
      4'd6:    seg_pat = 7'b1011111;
      4'd7:    seg_pat = 7'b1110000;
      4'd8:    seg_pat = 7'b1111111;
      4'd9:    seg_pat = 7'b1111011;
      default: seg_pat = 7'b0000000;
    endcase
  endfunction
  assign w_len  = (r_state == ONES || r_state == TENS) ? 16'(SCAN_DIV) : 16'(GAP_CYC);
  assign w_last = (r_cnt == w_len - 16'd1);
  // Shadow register follows every load strobe, independent of the scan position.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) r_shd <= 4'd0;
    else if (upd) r_shd <= data;
  end
  // Scan FSM: phase counter, state advance, frame-start latch of the shadow value and frame pulse.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      r_state <= GAP1;
      r_cnt   <= 16'd0;
      r_disp  <= 4'd0;
      r_frm   <= 1'b0;
    end else begin
      r_frm <= 1'b0;
      if (w_last) begin
        r_cnt   <= 16'd0;
        r_state <= state_t'(r_state + 2'd1);
        if (r_state == GAP1) begin
          r_disp <= r_shd;
          r_frm  <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
  assign w_tens       = (r_disp >= 4'd10);
  assign w_ones       = w_tens ? r_disp - 4'd10 : r_disp;
  assign w_blank_tens = blank_lz && !w_tens;
  // Digit drive is decoded from registered state only; blank_lz acts live within the tens phase.
  always_comb begin
    sel = (r_state == ONES) ? 2'b10 : (r_state == TENS && !w_blank_tens) ? 2'b01 : 2'b11;
    seg = (r_state == ONES) ? seg_pat(w_ones) :
          (r_state == TENS && !w_blank_tens) ? seg_pat({3'b000, w_tens}) : 7'b0000000;
  end
  assign ovf = w_tens;
  assign frm = r_frm;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with SCAN_DIV=4, GAP_CYC=1
module tb_seg_scan_driver;
  logic       clk = 1'b0;
  logic       cr;
  logic [3:0] data;
  logic       upd;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] sel;
  logic       ovf;
  logic       frm;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_sel = 2'b11;

  // One frame = 10 cycles starting at the first ONES cycle: ONES x4, GAP0, TENS x4, GAP1.
  typedef struct packed {
    logic [9:0][6:0] seg;
    logic [9:0][1:0] sel;
    logic [9:0]      ovf;
    logic [9:0]      frm;
  } frame_t;

  frame_t sb[$];
  logic [6:0] pat [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  seg_scan_driver #(.SCAN_DIV(4), .GAP_CYC(1)) dut (
    .clk(clk), .cr(cr), .data(data), .upd(upd), .blank_lz(blank_lz),
    .seg(seg), .sel(sel), .ovf(ovf), .frm(frm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Scan-safety monitor: never both digits on, and a lit digit never hands directly to the other.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sel === 2'b00) begin errors++; $display("FAIL sel_both_on got=%b", sel); end
      checks++;
      if (sel !== 2'b11 && prev_sel !== 2'b11 && sel !== prev_sel) begin
        errors++; $display("FAIL no_gap got=%b prev=%b need gap 11 between", sel, prev_sel);
      end
      prev_sel = sel;
    end else prev_sel = 2'b11;
  end

  function automatic frame_t make_frame(int v, bit blz);
    frame_t f = '0;
    for (int i = 0; i < 10; i++) begin
      f.sel[i] = 2'b11;
      f.ovf[i] = (v >= 10);
    end
    for (int i = 0; i < 4; i++) begin
      f.sel[i] = 2'b10;
      f.seg[i] = pat[v % 10];
    end
    if (!(blz && v < 10))
      for (int i = 5; i < 9; i++) begin
        f.sel[i] = 2'b01;
        f.seg[i] = pat[v / 10];
      end
    f.frm[0] = 1'b1;
    return f;
  endfunction

  // Waits (bounded) for the next frame pulse, then records the 10 cycles of that frame.
  task automatic capture(output frame_t f, output int n);
    f = '0;
    for (n = 0; n < 40 && frm !== 1'b1; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      f.seg[i] = seg;
      f.sel[i] = sel;
      f.ovf[i] = ovf;
      f.frm[i] = frm;
    end
  endtask

  task automatic test_reset;
    frame_t got, exp;
    int n;
    cr = 1'b0; data = 4'd0; upd = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
    checks++; if (sel !== 2'b11) begin errors++; $display("FAIL reset_sel got=%b exp=11", sel); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (frm !== 1'b0) begin errors++; $display("FAIL reset_frm got=%b exp=0", frm); end
    cr = 1'b1;
    checks++; if (sel !== 2'b11) begin errors++; $display("FAIL release_blank got=%b exp=11", sel); end
    sb.push_back(make_frame(0, 1'b0));
    sb.push_back(make_frame(0, 1'b0));
    repeat (2) begin
      capture(got, n);
      exp = sb.pop_front();
      checks++; if (n !== 1) begin errors++; $display("FAIL reset_lead got=%0d exp=1", n); end
      checks++; if (got !== exp) begin errors++; $display("FAIL reset_frame got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_same_cycle_update;
    frame_t got, exp;
    int n;
    sb.push_back(make_frame(0, 1'b0));
    sb.push_back(make_frame(13, 1'b0));
    data = 4'd13; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    repeat (2) begin
      capture(got, n);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL same_cycle_frame got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_blank;
    frame_t got, exp;
    int n;
    @(negedge clk);
    data = 4'd7; upd = 1'b1; blank_lz = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    sb.push_back(make_frame(7, 1'b1));
    capture(got, n);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL blank_frame got=%h exp=%h", got, exp); end
  endtask

  task automatic test_blank_live;
    @(negedge clk);
    checks++; if (frm !== 1'b1) begin errors++; $display("FAIL live_frm got=%b exp=1", frm); end
    repeat (5) @(negedge clk);
    checks++; if (sel !== 2'b11 || seg !== 7'b0000000) begin
      errors++; $display("FAIL live_blanked got=%b/%b exp=11/0000000", sel, seg);
    end
    blank_lz = 1'b0;
    #1;
    checks++; if (sel !== 2'b01 || seg !== 7'b1111110) begin
      errors++; $display("FAIL live_unblank got=%b/%b exp=01/1111110", sel, seg);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_no_tearing;
    frame_t got, exp;
    int n;
    sb.push_back(make_frame(7, 1'b0));
    sb.push_back(make_frame(15, 1'b0));
    fork
      capture(got, n);
      begin
        repeat (2) @(negedge clk);
        data = 4'd9; upd = 1'b1;
        @(negedge clk);
        data = 4'd15;
        @(negedge clk);
        upd = 1'b0;
      end
    join
    exp = sb.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL tearing_cur got=%h exp=%h", got, exp); end
    capture(got, n);
    exp = sb.pop_front();
    checks++; if (n !== 1) begin errors++; $display("FAIL tearing_period got=%0d exp=1", n); end
    checks++; if (got !== exp) begin errors++; $display("FAIL tearing_next got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid;
    frame_t got, exp;
    int n;
    repeat (8) @(negedge clk);
    checks++; if (sel !== 2'b01 || ovf !== 1'b1) begin
      errors++; $display("FAIL mid_pre got=%b/%b exp=01/1", sel, ovf);
    end
    #2 cr = 1'b0;
    #1;
    checks++; if (sel !== 2'b11 || seg !== 7'b0000000 || ovf !== 1'b0 || frm !== 1'b0) begin
      errors++; $display("FAIL mid_async got=%b/%b/%b/%b exp=11/0000000/0/0", sel, seg, ovf, frm);
    end
    repeat (2) @(negedge clk);
    cr = 1'b1;
    checks++; if (sel !== 2'b11) begin errors++; $display("FAIL mid_release got=%b exp=11", sel); end
    sb.push_back(make_frame(0, 1'b0));
    capture(got, n);
    exp = sb.pop_front();
    checks++; if (n !== 1) begin errors++; $display("FAIL mid_lead got=%0d exp=1", n); end
    checks++; if (got !== exp) begin errors++; $display("FAIL mid_frame got=%h exp=%h", got, exp); end
  endtask

  task automatic test_sweep;
    frame_t got, exp;
    int n;
    mon_en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      data = 4'(v); upd = 1'b1; blank_lz = v[0];
      @(negedge clk);
      upd = 1'b0;
      sb.push_back(make_frame(v, v[0]));
      capture(got, n);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL sweep_%0d got=%h exp=%h", v, got, exp); end
    end
    mon_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_same_cycle_update;
    test_blank;
    test_blank_live;
    test_no_tearing;
    test_reset_mid;
    test_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
